// File: rtl/clock_div_pkg.sv
// Shared definitions for the clock-enable sequencer: FSM state encoding and
// sizing of the per-channel lock counter.
package clock_div_pkg;

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_LOAD,
      ST_SETTLE,
      ST_RUN
   } state_t;

   // The lock counter must be able to hold the saturated value itself.
   function automatic int lock_cnt_w(input int periods);
      return (periods < 1) ? 1 : $clog2(periods + 1);
   endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: period counter, enable strobe, square wave and a
// saturating count of completed periods that drives the locked flag.
module clock_div_channel
   import clock_div_pkg::*;
#(
   parameter int DIV_W        = 5,
   parameter int LOCK_PERIODS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] ratio,
   input  logic             load,
   input  logic             run_en,
   output logic             en,
   output logic             div,
   output logic             locked
);

   localparam int            LW       = lock_cnt_w(LOCK_PERIODS);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_PERIODS);

   logic [DIV_W-1:0] cnt;
   logic [LW-1:0]    lock_cnt;
   logic             ratio_off;
   logic             at_wrap;

   assign ratio_off = (ratio == '0);
   assign at_wrap   = (cnt == ratio - DIV_W'(1));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         lock_cnt <= '0;
      end else if (load) begin
         cnt      <= '0;
         lock_cnt <= '0;
      end else if (run_en && !ratio_off) begin
         cnt <= at_wrap ? '0 : cnt + DIV_W'(1);
         if (at_wrap && (lock_cnt != LOCK_MAX))
            lock_cnt <= lock_cnt + LW'(1);
      end
   end

   // Ratio 1 wraps every cycle, so it strobes constantly and its half-period is 0.
   assign en     = run_en && !ratio_off && at_wrap;
   assign div    = run_en && (cnt < (ratio >> 1));
   assign locked = run_en && (ratio_off || (lock_cnt == LOCK_MAX));

endmodule

// File: rtl/clock_div_sequencer.sv
// Multi-channel clock-enable generator with startup reset sequencing, a
// ratio-load handshake and a global ready derived from per-channel lock.
module clock_div_sequencer
   import clock_div_pkg::*;
#(
   parameter int NUM_CH       = 2,
   parameter int DIV_W        = 5,
   parameter int RST_CYCLES   = 32768,
   parameter int LOCK_PERIODS = 4
) (
   input  logic                    MASTER_CLOCK_O,
   input  logic                    RESETN_I,
   input  logic [NUM_CH*DIV_W-1:0] DIV_RATIO_I,
   input  logic                    DIV_REQ_I,
   output logic                    DIV_ACK_O,
   output logic                    SUB_RESET_O,
   output logic [NUM_CH-1:0]       CLK_EN_O,
   output logic [NUM_CH-1:0]       CLK_DIV_O,
   output logic [NUM_CH-1:0]       CH_LOCKED_O,
   output logic                    CLOCK_READY_O
);

   localparam int             RCW      = $clog2(RST_CYCLES);
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [RCW-1:0]          rst_cnt;
   logic [NUM_CH*DIV_W-1:0] ratio_q;
   logic [NUM_CH-1:0]       locked;
   logic                    load_d;
   logic                    req_valid;
   logic                    load;
   logic                    run_en;

   always_ff @(posedge MASTER_CLOCK_O or negedge RESETN_I) begin
      if (!RESETN_I) state <= ST_HOLD;
      else           state <= state_nxt;
   end

   // A request still high in the cycle right after the ack is the old one.
   assign req_valid = DIV_REQ_I && !load_d;

   always_comb begin
      // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         ST_HOLD:   if (rst_cnt == RST_LAST) state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_SETTLE;
         ST_SETTLE: begin
            if (req_valid)    state_nxt = ST_LOAD;
            else if (&locked) state_nxt = ST_RUN;
         end
         ST_RUN:    if (req_valid) state_nxt = ST_LOAD;
         default:   state_nxt = ST_HOLD;
      endcase
   end

   always_comb begin
      SUB_RESET_O   = (state == ST_HOLD);
      load          = (state == ST_LOAD);
      DIV_ACK_O     = load;
      run_en        = (state == ST_SETTLE) || (state == ST_RUN);
      CLOCK_READY_O = (state == ST_RUN) && (&locked);
   end

   // NOTE: the ratio bank is an ordinary register array, so it takes the async
   // reset like the rest of the state rather than being left uninitialised.
   always_ff @(posedge MASTER_CLOCK_O or negedge RESETN_I) begin
      if (!RESETN_I) begin
         rst_cnt <= '0;
         ratio_q <= '0;
         load_d  <= 1'b0;
      end else begin
         if (state == ST_HOLD) rst_cnt <= rst_cnt + RCW'(1);
         if (load)             ratio_q <= DIV_RATIO_I;
         load_d <= load;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      clock_div_channel #(
         .DIV_W        (DIV_W),
         .LOCK_PERIODS (LOCK_PERIODS)
      ) u_ch (
         .clk    (MASTER_CLOCK_O),
         .rst_n  (RESETN_I),
         .ratio  (ratio_q[k*DIV_W +: DIV_W]),
         .load   (load),
         .run_en (run_en),
         .en     (CLK_EN_O[k]),
         .div    (CLK_DIV_O[k]),
         .locked (locked[k])
      );
   end

   assign CH_LOCKED_O = locked;

endmodule

// File: tb/tb_clock_div_sequencer.sv
// Bench for clock_div_sequencer: expected per-cycle output vectors are derived
// from cycle index k since the LOAD cycle, queued, then popped against the DUT.
module tb_clock_div_sequencer;

   localparam int NUM_CH     = 2;
   localparam int DIV_W      = 5;
   localparam int RST_CYCLES = 16;
   localparam int LOCK_P     = 4;

   typedef struct packed {
      logic       ack;
      logic       sub_rst;
      logic [1:0] en;
      logic [1:0] div;
      logic [1:0] locked;
      logic       ready;
   } obs_t;

   logic                    clk = 1'b0;
   logic                    rstn;
   logic [NUM_CH*DIV_W-1:0] ratio;
   logic                    req;
   logic                    ack;
   logic                    sub_rst;
   logic [NUM_CH-1:0]       en;
   logic [NUM_CH-1:0]       div;
   logic [NUM_CH-1:0]       locked;
   logic                    ready;

   int   checks   = 0;
   int   failures = 0;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   clock_div_sequencer #(
      .NUM_CH       (NUM_CH),
      .DIV_W        (DIV_W),
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_PERIODS (LOCK_P)
   ) dut (
      .MASTER_CLOCK_O (clk),
      .RESETN_I       (rstn),
      .DIV_RATIO_I    (ratio),
      .DIV_REQ_I      (req),
      .DIV_ACK_O      (ack),
      .SUB_RESET_O    (sub_rst),
      .CLK_EN_O       (en),
      .CLK_DIV_O      (div),
      .CH_LOCKED_O    (locked),
      .CLOCK_READY_O  (ready)
   );

   function automatic obs_t observe();
      obs_t o;
      o = {ack, sub_rst, en, div, locked, ready};
      return o;
   endfunction

   function automatic obs_t reset_obs();
      obs_t o;
      o = '0;
      o.sub_rst = 1'b1;
      return o;
   endfunction

   function automatic logic [NUM_CH*DIV_W-1:0] pack(input int r0, input int r1);
      return {DIV_W'(r1), DIV_W'(r0)};
   endfunction

   // First cycle k at which a channel of ratio r shows locked.
   function automatic int lock_k(input int r);
      return (r == 0) ? 1 : LOCK_P * r + 1;
   endfunction

   // {en, div, locked} for one channel, k cycles after the LOAD cycle (k >= 1).
   function automatic logic [2:0] ch_model(input int k, input int r);
      int c;
      if (r == 0) return 3'b001;
      c = (k - 1) % r;
      return {(c == r - 1), (c < r / 2), (k >= lock_k(r))};
   endfunction

   function automatic obs_t model(input int k, input int r0, input int r1);
      obs_t       o;
      logic [2:0] c0;
      logic [2:0] c1;
      int         lk;
      o = '0;
      if (k == 0) begin
         o.ack = 1'b1;
         return o;
      end
      c0       = ch_model(k, r0);
      c1       = ch_model(k, r1);
      o.en     = {c1[2], c0[2]};
      o.div    = {c1[1], c0[1]};
      o.locked = {c1[0], c0[0]};
      lk       = (lock_k(r0) > lock_k(r1)) ? lock_k(r0) : lock_k(r1);
      o.ready  = (k >= lk + 1);
      return o;
   endfunction

   // Starts at the negedge sample of a LOAD cycle (k = 0); drops req after sample drop_k.
   task automatic run_window(input string name, input int r0, input int r1,
                             input int ncyc, input int drop_k);
      obs_t got;
      obs_t want;
      for (int k = 0; k < ncyc; k++) exp_q.push_back(model(k, r0, r1));
      for (int k = 0; k < ncyc; k++) begin
         if (k > 0) @(negedge clk);
         got  = observe();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL %s k=%0d got=%b want=%b (ack,sub,en,div,locked,ready)",
                     name, k, got, want);
         end
         if (k == drop_k) req = 1'b0;
      end
   endtask

   // Releases reset after a posedge and measures how long SUB_RESET stays high.
   task automatic release_and_count(input string name);
      int n;
      n = 0;
      @(posedge clk);
      #1 rstn = 1'b1;
      while (n < 100) begin
         @(negedge clk);
         if (!sub_rst) break;
         n++;
         checks++;
         if (ack !== 1'b0) begin
            failures++;
            $display("FAIL %s_ack_in_hold cycle=%0d got=%b want=0", name, n, ack);
         end
      end
      checks++;
      if (n != RST_CYCLES) begin
         failures++;
         $display("FAIL %s_hold_len got=%0d want=%0d", name, n, RST_CYCLES);
      end
   endtask

   // Called at a negedge after req is raised; the ack must come one cycle later.
   task automatic wait_ack(input string name);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (ack !== 1'b1 && lat < 10);
      checks++;
      if (ack !== 1'b1 || lat != 1) begin
         failures++;
         $display("FAIL %s ack=%b latency=%0d want ack=1 latency=1", name, ack, lat);
      end
   endtask

   task automatic check_ready_high(input string name);
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready=%b want=1", name, ready);
      end
   endtask

   task automatic test_reset();
      obs_t got;
      rstn  = 1'b1;
      req   = 1'b0;
      ratio = pack(7, 16);
      #1 rstn = 1'b0;
      #1 got = observe();
      checks++;
      if (got !== reset_obs()) begin
         failures++;
         $display("FAIL reset_async got=%b want=%b", got, reset_obs());
      end
      @(posedge clk);
      @(posedge clk);
      #1 got = observe();
      checks++;
      if (got !== reset_obs()) begin
         failures++;
         $display("FAIL reset_held got=%b want=%b", got, reset_obs());
      end
      release_and_count("startup");
   endtask

   task automatic test_divide_lock();
      run_window("divide_lock", 7, 16, 70, 0);
   endtask

   task automatic test_update();
      check_ready_high("update_ready_before");
      ratio = pack(3, 0);
      req   = 1'b1;
      wait_ack("update_ack");
      run_window("update", 3, 0, 20, 0);
   endtask

   task automatic test_back_to_back();
      check_ready_high("b2b_ready_before");
      ratio = pack(5, 2);
      req   = 1'b1;
      wait_ack("b2b_ack");
      // Request still high at the edge after the ack: must not be taken again.
      run_window("req_held_one", 5, 2, 25, 2);
      check_ready_high("repeat_ready_before");
      ratio = pack(4, 6);
      req   = 1'b1;
      wait_ack("repeat_ack");
      // Held across two edges after the ack: a second LOAD three cycles later.
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (ack !== (k == 3)) begin
            failures++;
            $display("FAIL repeat_req k=%0d ack=%b want=%b", k, ack, (k == 3));
         end
      end
      run_window("repeat_req_window", 4, 6, 30, 0);
   endtask

   task automatic test_ratio_one();
      check_ready_high("ratio_one_ready_before");
      ratio = pack(1, 4);
      req   = 1'b1;
      wait_ack("ratio_one_ack");
      run_window("ratio_one", 1, 4, 25, 0);
   endtask

   task automatic test_async_reset();
      obs_t got;
      check_ready_high("async_ready_before");
      #2 rstn = 1'b0;
      #1 got = observe();
      checks++;
      if (got !== reset_obs()) begin
         failures++;
         $display("FAIL async_reset_mid_run got=%b want=%b", got, reset_obs());
      end
      ratio = pack(7, 16);
      @(posedge clk);
      @(posedge clk);
      release_and_count("rerun");
      run_window("rerun_window", 7, 16, 30, 0);
   endtask

   task automatic test_hold_request();
      @(negedge clk);
      rstn  = 1'b0;
      req   = 1'b1;
      ratio = pack(2, 9);
      @(posedge clk);
      release_and_count("hold_req");
      run_window("hold_req_window", 2, 9, 45, 0);
   endtask

   initial begin
      test_reset();
      test_divide_lock();
      test_update();
      test_back_to_back();
      test_ratio_one();
      test_async_reset();
      test_hold_request();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
